// File: rtl/mouse_pos_tracker.sv
// mouse_pos_tracker
//   Decodes the 3-byte PS/2 mouse movement packet stream and integrates the
//   signed X/Y deltas into absolute cursor coordinates, clamped to the screen.
//   Everything is in the pixel clock domain.
// Ports
//   clk       in   pixel clock, posedge
//   rst       in   synchronous active-high reset
//   rx_data   in   [7:0] received PS/2 byte
//   rx_valid  in   1-cycle strobe qualifying rx_data
//   xpos      out  [11:0] cursor X, 0..MAX_X-1
//   ypos      out  [11:0] cursor Y, 0..MAX_Y-1 (0 = top)
//   btn_left  out  left button from last committed packet
//   btn_right out  right button
//   btn_mid   out  middle button
//   pos_valid out  1-cycle pulse, position/buttons just updated
//   sync_err  out  1-cycle pulse, a byte was rejected as a header
module mouse_pos_tracker #(
  parameter int MAX_X       = 800,
  parameter int MAX_Y       = 600,
  parameter int INIT_X      = 400,
  parameter int INIT_Y      = 300,
  parameter int TIMEOUT_CYC = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_mid,
  output logic        pos_valid,
  output logic        sync_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3} state_t;

  state_t          state;
  logic [2:0]      hdr_btn;    // {M,R,L}
  logic [3:0]      hdr_flg;    // {Yovf,Xovf,Ysign,Xsign}
  logic [7:0]      dx_lo;
  logic [CW-1:0]   cnt;

  logic signed [12:0] dx, dy, nx, ny;
  logic [11:0]        cx, cy;

  function automatic logic [11:0] clamp(input logic signed [12:0] v, input int maxv);
    logic signed [12:0] lim;
    lim = 13'(maxv - 1);
    if (v < 13'sd0)   return 12'd0;
    else if (v > lim) return lim[11:0];
    else              return v[11:0];
  endfunction

  // The Y byte is taken straight off rx_data so the packet commits on the
  // edge that samples the third byte, leaving the next cycle free for a
  // new header.
  always_comb begin
    dx = hdr_flg[2] ? 13'sd0 : {{4{hdr_flg[0]}}, hdr_flg[0], dx_lo};
    dy = hdr_flg[3] ? 13'sd0 : {{4{hdr_flg[1]}}, hdr_flg[1], rx_data};
    nx = $signed({1'b0, xpos}) + dx;
    ny = $signed({1'b0, ypos}) - dy;   // PS/2 +dY is up, screen Y grows down
    cx = clamp(nx, MAX_X);
    cy = clamp(ny, MAX_Y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_B1;
      hdr_btn   <= '0;
      hdr_flg   <= '0;
      dx_lo     <= '0;
      cnt       <= '0;
      xpos      <= 12'(INIT_X);
      ypos      <= 12'(INIT_Y);
      btn_left  <= 1'b0;
      btn_right <= 1'b0;
      btn_mid   <= 1'b0;
      pos_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (rx_valid) begin
        cnt <= '0;
        unique case (state)
          WAIT_B1: begin
            if (rx_data[3]) begin
              hdr_btn <= rx_data[2:0];
              hdr_flg <= rx_data[7:4];
              state   <= WAIT_B2;
            end else begin
              sync_err <= 1'b1;
            end
          end
          WAIT_B2: begin
            dx_lo <= rx_data;
            state <= WAIT_B3;
          end
          WAIT_B3: begin
            xpos      <= cx;
            ypos      <= cy;
            btn_left  <= hdr_btn[0];
            btn_right <= hdr_btn[1];
            btn_mid   <= hdr_btn[2];
            pos_valid <= 1'b1;
            state     <= WAIT_B1;
          end
          default: state <= WAIT_B1;
        endcase
      end else if (state != WAIT_B1) begin
        // Idle mid-packet: drop the partial packet at terminal count.
        if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          cnt   <= '0;
          state <= WAIT_B1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
module tb_mouse_pos_tracker;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] xpos, ypos;
  logic        btn_left, btn_right, btn_mid, pos_valid, sync_err;

  mouse_pos_tracker #(.MAX_X(800), .MAX_Y(600), .INIT_X(400), .INIT_Y(300),
                      .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .xpos(xpos), .ypos(ypos), .btn_left(btn_left), .btn_right(btn_right),
    .btn_mid(btn_mid), .pos_valid(pos_valid), .sync_err(sync_err));

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] b;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   mx = 400, my = 300;
  logic [2:0] mb = 3'b000;
  int   exp_serr = 0, obs_serr = 0;
  logic prev_pv = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every commit pulse pops one expected packet result.
  always @(negedge clk) begin
    if (sync_err) obs_serr++;
    if (pos_valid) begin
      chk("pv_1clk", int'(prev_pv), 0);
      if (q.size() == 0) begin
        chk("pv_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xpos", int'(xpos), e.x);
        chk("ypos", int'(ypos), e.y);
        chk("btns", int'({btn_mid, btn_right, btn_left}), int'(e.b));
        chk("latency", cyc, e.cyc);
      end
    end
    prev_pv <= pos_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference model for one full packet, computed in plain integers.
  task automatic push_exp(input logic [7:0] h, input logic [7:0] b2, input logic [7:0] b3);
    exp_t e;
    int dx, dy;
    dx = h[6] ? 0 : int'(b2) - (h[4] ? 256 : 0);
    dy = h[7] ? 0 : int'(b3) - (h[5] ? 256 : 0);
    mx = mx + dx;
    my = my - dy;
    if (mx < 0) mx = 0;
    if (mx > 799) mx = 799;
    if (my < 0) my = 0;
    if (my > 599) my = 599;
    mb = h[2:0];
    e.x = mx; e.y = my; e.b = mb; e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic pkt(input logic [7:0] h, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(h);
    send_byte(b2);
    push_exp(h, b2, b3);
    send_byte(b3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mx = 400; my = 300; mb = 3'b000;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    rst = 1'b0;
    mx = 400; my = 300; mb = 3'b000;
    idle(5);
    chk("rst_x", int'(xpos), 400);
    chk("rst_y", int'(ypos), 300);
    chk("rst_btn", int'({btn_mid, btn_right, btn_left}), 0);
    chk("rst_pv", int'(pos_valid), 0);
    chk("rst_serr", int'(sync_err), 0);

    // basic move
    pkt(8'h08, 8'h05, 8'h03);
    idle(1);
    chk("basic_x", int'(xpos), 405);
    chk("basic_y", int'(ypos), 297);

    // left clamp: 400 -> 10 by -10 steps, -8 to 2, then -10 clamps to 0
    do_reset();
    pkt(8'h18, 8'hF6, 8'h00);
    idle(1);
    chk("x_minus10", int'(xpos), 390);
    while (mx > 10) pkt(8'h18, 8'hF6, 8'h00);
    pkt(8'h18, 8'hF8, 8'h00);
    pkt(8'h18, 8'hF6, 8'h00);
    idle(1);
    chk("x_clamp0", int'(xpos), 0);

    // right clamp: reach 795 then +10, back-to-back packets
    repeat (6) pkt(8'h08, 8'h7F, 8'h00);
    pkt(8'h08, 8'h21, 8'h00);
    idle(1);
    chk("x_795", int'(xpos), 795);
    pkt(8'h08, 8'h0A, 8'h00);
    idle(1);
    chk("x_clamp799", int'(xpos), 799);

    // top clamp: reach y=5 then move up 10
    pkt(8'h08, 8'h00, 8'h7F);
    pkt(8'h08, 8'h00, 8'h7F);
    pkt(8'h08, 8'h00, 8'h29);
    idle(1);
    chk("y_5", int'(ypos), 5);
    pkt(8'h08, 8'h00, 8'h0A);
    idle(1);
    chk("y_clamp0", int'(ypos), 0);

    // bottom clamp: move down (negative dY) past 599
    repeat (5) pkt(8'h28, 8'h00, 8'h81);

    // X overflow: position unchanged, button taken
    pkt(8'h49, 8'h7F, 8'h00);
    idle(2);

    // bad header
    exp_serr++;
    send_byte(8'h00);
    idle(2);
    pkt(8'h0A, 8'h01, 8'h01);
    idle(2);

    // timeout after byte 2 drops the packet
    send_byte(8'h08);
    send_byte(8'h05);
    idle(TO);
    pkt(8'h09, 8'h01, 8'h00);
    idle(2);

    // byte arriving on the terminal count still belongs to the packet
    send_byte(8'h08);
    send_byte(8'h05);
    idle(TO - 1);
    push_exp(8'h08, 8'h05, 8'h00);
    send_byte(8'h00);
    idle(2);

    // reset mid-packet
    pkt(8'h08, 8'h20, 8'h10);
    send_byte(8'h0C);
    send_byte(8'h05);
    do_reset();
    idle(1);
    chk("rst_mid_x", int'(xpos), 400);
    chk("rst_mid_y", int'(ypos), 300);
    chk("rst_mid_btn", int'({btn_mid, btn_right, btn_left}), 0);
    pkt(8'h09, 8'h01, 8'h00);
    idle(2);

    // random packets with random gaps, some bad headers in between
    for (int i = 0; i < 40; i++) begin
      logic [7:0] h, b2, b3;
      h  = 8'($urandom) | 8'h08;
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        exp_serr++;
        send_byte(8'($urandom) & 8'hF7);
      end
      pkt(h, b2, b3);
      idle($urandom_range(0, 3));
    end

    idle(5);
    chk("sb_empty", q.size(), 0);
    chk("sync_err_cnt", obs_serr, exp_serr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
